ag32gbd_ram_read: RTL

Reads one 256-byte round of cart SRAM bank0 (addresses {round[3:0], offset[7:0]}) and converts it from Game Boy planar tile layout back into the linear 2bpp block-buffer layout (4 pixels/byte, MSB = leftmost pixel, 32 bytes/row, 8 rows).
It is the read-side counterpart of the SRAM tile writer and shares the same SRAM pins through the top-level mux.
It feeds the block buffer's write port so a captured picture can be dumped back out of SRAM.

---
 rtl/ag32gbd_ram_read.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ag32gbd_ram_read.sv
`default_nettype none
// ============================================================================
// Module   : ag32gbd_ram_read
// Purpose  : Reads one 256-byte SRAM round and re-linearises GB planar tiles
//            into 2bpp block-buffer bytes.
// Revision : 1.0
// ============================================================================
module ag32gbd_ram_read #(
  parameter int READ_WAIT = 8
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        NewRunReset,
  input  logic        StartRead,
  input  logic [3:0]  ReadRound,
  input  logic        Gbd_Writing_Ram,
  output logic        Gbd_Reading_Ram,
  output logic [11:0] Ram_Reading_Addr_Low,
  input  logic [7:0]  Ram_Reading_Data,
  output logic        Ram_Reading_nCS,
  output logic        Ram_Reading_nOE,
  output logic        BufferWriteEnable,
  output logic [9:0]  BufferWriteOffset,
  output logic [7:0]  BufferWriteData,
  output logic        ReadDone
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ_LO = 3'd1,
    S_READ_HI = 3'd2,
    S_WRITE_1 = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [3:0] c_WAIT_LAST = 4'(READ_WAIT - 1);

  // Pairs one nibble of each plane into four 2-bit pixels, high plane as MSB.
  function automatic logic [7:0] f_interleave(input logic [3:0] hi, input logic [3:0] lo);
    logic [7:0] res;
    res = 8'h00;
    for (int i = 0; i < 4; i++) begin
      res[2*i+1] = hi[i];
      res[2*i]   = lo[i];
    end
    return res;
  endfunction

  state_t      r_state, w_state;
  logic [6:0]  r_k, w_k;
  logic [3:0]  r_wait, w_wait;
  logic [3:0]  r_round, w_round;
  logic [7:0]  r_lo, w_lo;
  logic [7:0]  r_hi, w_hi;
  logic [11:0] r_addr, w_addr;
  logic        r_ncs, w_ncs;
  logic        r_noe, w_noe;
  logic        r_we, w_we;
  logic [9:0]  r_off, w_off;
  logic [7:0]  r_data, w_data;
  logic        r_done, w_done;

  logic        w_rst_n;
  logic        w_sample;
  logic [11:0] w_addr_inc;

  // An abort request behaves exactly like the async reset.
  assign w_rst_n    = sys_resetn & ~NewRunReset;
  assign w_sample   = (r_wait == c_WAIT_LAST);
  assign w_addr_inc = {r_round, r_addr[7:0] + 8'd1};

  always_ff @(posedge sys_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_k     <= 7'd0;
      r_wait  <= 4'd0;
      r_round <= 4'd0;
      r_lo    <= 8'h00;
      r_hi    <= 8'h00;
      r_addr  <= 12'h000;
      r_ncs   <= 1'b1;
      r_noe   <= 1'b1;
      r_we    <= 1'b0;
      r_off   <= 10'd0;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_k     <= w_k;
      r_wait  <= w_wait;
      r_round <= w_round;
      r_lo    <= w_lo;
      r_hi    <= w_hi;
      r_addr  <= w_addr;
      r_ncs   <= w_ncs;
      r_noe   <= w_noe;
      r_we    <= w_we;
      r_off   <= w_off;
      r_data  <= w_data;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_k     = r_k;
    w_wait  = r_wait;
    w_round = r_round;
    w_lo    = r_lo;
    w_hi    = r_hi;
    w_addr  = r_addr;
    w_ncs   = r_ncs;
    w_noe   = r_noe;
    w_we    = r_we;
    w_off   = r_off;
    w_data  = r_data;
    w_done  = r_done;

    case (r_state)
      S_IDLE: begin
        w_done = 1'b0;
        w_we   = 1'b0;
        if (StartRead && !Gbd_Writing_Ram) begin
          w_round = ReadRound;
          w_k     = 7'd0;
          w_addr  = {ReadRound, 8'h00};
          w_ncs   = 1'b0;
          w_noe   = 1'b0;
          w_wait  = 4'd0;
          w_state = S_READ_LO;
        end
      end
      S_READ_LO: begin
        w_we = 1'b0;
        if (w_sample) begin
          w_lo    = Ram_Reading_Data;
          w_addr  = w_addr_inc;
          w_wait  = 4'd0;
          w_state = S_READ_HI;
        end else begin
          w_wait = r_wait + 4'd1;
        end
      end
      S_READ_HI: begin
        if (w_sample) begin
          w_hi    = Ram_Reading_Data;
          w_we    = 1'b1;
          // Pair k covers row k[2:0], byte column k[6:3]*2 of the linear buffer.
          w_off   = {2'b00, r_k[2:0], r_k[6:3], 1'b0};
          w_data  = f_interleave(Ram_Reading_Data[7:4], r_lo[7:4]);
          w_wait  = 4'd0;
          w_state = S_WRITE_1;
        end else begin
          w_wait = r_wait + 4'd1;
        end
      end
      S_WRITE_1: begin
        w_we   = 1'b1;
        w_off  = {2'b00, r_k[2:0], r_k[6:3], 1'b1};
        w_data = f_interleave(r_hi[3:0], r_lo[3:0]);
        w_addr = w_addr_inc;
        if (r_k == 7'd127) begin
          w_state = S_FINISH;
        end else begin
          w_k     = r_k + 7'd1;
          w_state = S_READ_LO;
        end
      end
      S_FINISH: begin
        w_we    = 1'b0;
        w_ncs   = 1'b1;
        w_noe   = 1'b1;
        w_addr  = 12'h000;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign Gbd_Reading_Ram      = (r_state != S_IDLE);
  assign Ram_Reading_Addr_Low = r_addr;
  assign Ram_Reading_nCS      = r_ncs;
  assign Ram_Reading_nOE      = r_noe;
  assign BufferWriteEnable    = r_we;
  assign BufferWriteOffset    = r_off;
  assign BufferWriteData      = r_data;
  assign ReadDone             = r_done;

endmodule
`default_nettype wire
